// File: rtl/dist_ram_stream_ctrl.sv
// dist_ram_stream_ctrl
//   Packet store-and-forward controller in front of an external 256x8
//   distributed RAM with asynchronous read. A packet is loaded from the
//   upstream byte stream, held until drain_start_in, then streamed out
//   downstream with valid/ready handshaking.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   s_valid_in/s_data_in/s_last_in/s_ready_out
//                           upstream byte stream
//   drain_start_in          request readout of the held packet
//   m_valid_out/m_data_out/m_last_out/m_ready_in
//                           downstream byte stream
//   ram_write_en_out, ram_address_out, ram_data_out, ram_rdata_in
//                           external RAM port
//   count_out               bytes stored (0..256)
//   overflow_err_out        sticky: 256 bytes accepted without s_last_in
//   checksum_out            XOR of packet bytes (only with DRAM_CHECKSUM_EN)
//
// Configuration macro: DRAM_CHECKSUM_EN
module dist_ram_stream_ctrl (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       s_valid_in,
    input  logic [7:0] s_data_in,
    input  logic       s_last_in,
    output logic       s_ready_out,
    input  logic       drain_start_in,
    output logic       m_valid_out,
    output logic [7:0] m_data_out,
    output logic       m_last_out,
    input  logic       m_ready_in,
    output logic       ram_write_en_out,
    output logic [7:0] ram_address_out,
    output logic [7:0] ram_data_out,
    input  logic [7:0] ram_rdata_in,
    output logic [8:0] count_out,
    output logic       overflow_err_out
`ifdef DRAM_CHECKSUM_EN
    ,
    output logic [7:0] checksum_out
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [8:0] count;
    logic       overflow;
    logic       accept;
    logic       in_drain;
    logic       last_beat;

    assign in_drain    = (state == DRAIN);
    assign s_ready_out = (state == IDLE) || (state == LOAD);

    // Gating with rst_n_in keeps the RAM write strobe quiet while reset is
    // held, even though s_ready_out already shows its IDLE value.
    assign accept = s_valid_in & s_ready_out & rst_n_in;

    // count holds up to 256, so the compare is done at 9 bits.
    assign last_beat = in_drain && ({1'b0, rd_ptr} == (count - 9'd1));

    assign ram_write_en_out = accept;
    assign ram_data_out     = s_data_in;
    assign ram_address_out  = in_drain ? rd_ptr : wr_ptr;

    // RAM is never written in DRAIN and rd_ptr only moves on a handshake,
    // so data/last stay stable through downstream stalls.
    assign m_valid_out = in_drain;
    assign m_data_out  = in_drain ? ram_rdata_in : '0;
    assign m_last_out  = last_beat;

    assign count_out        = count;
    assign overflow_err_out = overflow;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_ptr   <= wr_ptr + 8'd1;
                        count    <= count + 9'd1;
                        overflow <= 1'b0;
                        state    <= s_last_in ? HOLD : LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + 8'd1;
                        count  <= count + 9'd1;
                        if (s_last_in) begin
                            state <= HOLD;
                        end else if (count == 9'd255) begin
                            // 256th byte without an end marker: RAM is full.
                            state    <= HOLD;
                            overflow <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (drain_start_in) begin
                        rd_ptr <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (m_ready_in) begin
                        rd_ptr <= rd_ptr + 8'd1;
                        if (last_beat) begin
                            wr_ptr <= '0;
                            count  <= '0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DRAM_CHECKSUM_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            checksum_out <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                checksum_out <= s_data_in;
            end else begin
                checksum_out <= checksum_out ^ s_data_in;
            end
        end
    end
`endif

endmodule
